// File: rtl/fetch_target_queue_pkg.sv
// fetch_target_queue_pkg: shared predictor/FTQ types and sizing constants
package fetch_target_queue_pkg;
    localparam int FETCH_WIDTH = 4;
    localparam int DEF_FTQ_DEPTH = 8;
    localparam int NPC_OFS = $clog2(FETCH_WIDTH) + 2;
    typedef logic [$clog2(DEF_FTQ_DEPTH)-1:0] FtqPtrT;
    typedef struct packed {
        logic next;
        logic redirect;
        logic [31:0] target;
    } BpuReqSt;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [FETCH_WIDTH-1:0] valid;
    } BpuRspSt;
    typedef struct packed {
        logic [31:0] pc;
        logic [FETCH_WIDTH-1:0] mask;
    } FtqEntrySt;
    function automatic logic [31:0] align4(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_target_queue_if.sv
// fetch_target_queue_if: predictor, backend-flush and fetch-stage signals of the FTQ
interface fetch_target_queue_if;
    import fetch_target_queue_pkg::*;
    BpuReqSt bpu_req;
    BpuRspSt bpu_rsp;
    logic redirect_valid;
    logic [31:0] redirect_target;
    logic ftq_valid;
    logic ftq_ready;
    logic [31:0] ftq_pc;
    logic [FETCH_WIDTH-1:0] ftq_mask;
    modport master (
        output bpu_req, ftq_valid, ftq_pc, ftq_mask,
        input bpu_rsp, redirect_valid, redirect_target, ftq_ready
    );
    modport slave (
        input bpu_req, ftq_valid, ftq_pc, ftq_mask,
        output bpu_rsp, redirect_valid, redirect_target, ftq_ready
    );
endinterface

// File: rtl/fetch_target_queue_storage.sv
// ftq_storage: FTQ entry array, one write port and one asynchronous read port
module ftq_storage
    import fetch_target_queue_pkg::*;
#(
    parameter int DEPTH = DEF_FTQ_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input logic clk,
    input logic we,
    input logic [AW-1:0] waddr,
    input FtqEntrySt wdata,
    input logic [AW-1:0] raddr,
    output FtqEntrySt rdata
);
    FtqEntrySt mem [DEPTH];
    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_target_queue.sv
// fetch_target_queue: captures predicted fetch blocks into a circular FIFO for the fetch stage
module fetch_target_queue
    import fetch_target_queue_pkg::*;
#(
    parameter int FTQ_DEPTH = DEF_FTQ_DEPTH
) (
    input logic clk,
    input logic rst,
    fetch_target_queue_if.master bus
);
    localparam int PW = $clog2(FTQ_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FTQ_DEPTH);
    logic [PW-1:0] head_ptr, tail_ptr;
    logic [PW:0] count;
    logic next, redir, enq, deq;
    FtqEntrySt rdata;
    assign redir = !rst && bus.redirect_valid;
    assign next = !rst && !bus.redirect_valid && (count < FULL);
    assign enq = next && |bus.bpu_rsp.valid;
    assign bus.ftq_valid = !rst && !bus.redirect_valid && (count != '0);
    assign deq = bus.ftq_valid && bus.ftq_ready;
    assign bus.bpu_req = '{next: next, redirect: redir, target: redir ? align4(bus.redirect_target) : 32'h0};
    assign bus.ftq_pc = rdata.pc;
    assign bus.ftq_mask = rdata.mask;
    ftq_storage #(.DEPTH(FTQ_DEPTH)) u_storage (
        .clk(clk),
        .we(enq),
        .waddr(tail_ptr),
        .wdata('{pc: bus.bpu_rsp.pc, mask: bus.bpu_rsp.valid}),
        .raddr(head_ptr),
        .rdata(rdata)
    );
    // stale entries survive a flush; zeroing count alone makes them unreachable
    always_ff @(posedge clk) begin
        if (rst || bus.redirect_valid) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count <= '0;
        end else begin
            head_ptr <= head_ptr + PW'(deq);
            tail_ptr <= tail_ptr + PW'(enq);
            count <= count + (PW+1)'(enq) - (PW+1)'(deq);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(enq && count == FULL));
            assert (!(deq && count == '0));
            assert (!(bus.ftq_valid && bus.ftq_mask == '0));
        end
    end
endmodule

// File: tb/tb_fetch_target_queue.sv
// tb_fetch_target_queue: randomized FTQ bench with a queue-based reference model and a toy predictor
module tb_fetch_target_queue;
    import fetch_target_queue_pkg::*;
    typedef struct {
        logic [31:0] pc;
        logic [3:0] mask;
    } ent_t;
    logic clk = 0, rst = 1, rv = 0, ready = 0;
    logic [31:0] rt = 0;
    logic [31:0] pred_pc = 32'h1c000000;
    bit bubble, bubble_en;
    int n_chk, n_pass;
    ent_t q[$];
    fetch_target_queue_if bus();
    fetch_target_queue #(.FTQ_DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [3:0] slot_mask(input logic [31:0] pc);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (i >= int'(pc[3:2]));
        return m;
    endfunction
    assign bus.redirect_valid = rv;
    assign bus.redirect_target = rt;
    assign bus.ftq_ready = ready;
    assign bus.bpu_rsp = '{pc: pred_pc, npc: {pred_pc[31:4], 4'h0} + 32'h10,
                           valid: (bus.bpu_req.next && !bubble) ? slot_mask(pred_pc) : 4'h0};
    // toy predictor: sequential 16-byte blocks, occasional empty responses when bubble_en
    always @(posedge clk) begin
        bubble <= bubble_en && ($urandom_range(0, 3) == 0);
        if (rst) pred_pc <= 32'h1c000000;
        else if (bus.bpu_req.redirect) pred_pc <= bus.bpu_req.target;
        else if (bus.bpu_req.next && !bubble) pred_pc <= {pred_pc[31:4], 4'h0} + 32'h10;
    end
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction
    always @(negedge clk) begin
        bit en, ev;
        en = !rst && !rv && q.size() < 8;
        ev = !rst && !rv && q.size() != 0;
        chk("m_next", bus.bpu_req.next, en);
        chk("m_redirect", bus.bpu_req.redirect, !rst && rv);
        chk("m_target", bus.bpu_req.target, (!rst && rv) ? {rt[31:2], 2'b00} : 32'h0);
        chk("m_ftq_valid", bus.ftq_valid, ev);
        if (ev) begin
            chk("m_ftq_pc", bus.ftq_pc, q[0].pc);
            chk("m_ftq_mask", bus.ftq_mask, q[0].mask);
        end
        if (rst || rv) q.delete();
        else begin
            if (ev && ready) void'(q.pop_front());
            if (en && |bus.bpu_rsp.valid) q.push_back('{pc: bus.bpu_rsp.pc, mask: bus.bpu_rsp.valid});
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        @(negedge clk);
        chk("rst_next", bus.bpu_req.next, 0);
        chk("rst_valid", bus.ftq_valid, 0);
        chk("rst_target", bus.bpu_req.target, 0);
        tick;
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fill_next", bus.bpu_req.next, 1);
            chk("fill_pc", bus.bpu_rsp.pc, 32'h1c000000 + 32'h10 * i);
            chk("fill_valid", bus.ftq_valid, i != 0);
            tick;
        end
        @(negedge clk);
        chk("full_next", bus.bpu_req.next, 0);
        chk("full_head_pc", bus.ftq_pc, 32'h1c000000);
        chk("full_head_mask", bus.ftq_mask, 4'b1111);
        tick;
        ready = 1;
        @(negedge clk);
        chk("deq_full_next", bus.bpu_req.next, 0);
        chk("deq_full_pc", bus.ftq_pc, 32'h1c000000);
        tick;
        @(negedge clk);
        chk("refill_next", bus.bpu_req.next, 1);
        chk("refill_rsp_pc", bus.bpu_rsp.pc, 32'h1c000080);
        chk("refill_head", bus.ftq_pc, 32'h1c000010);
        tick;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stream_pc", bus.ftq_pc, 32'h1c000020 + 32'h10 * k);
            tick;
        end
        ready = 0;
        rst = 1;
        tick;
        rst = 0;
        repeat (5) tick;
        rv = 1;
        rt = 32'h1c000108;
        @(negedge clk);
        chk("redir_flag", bus.bpu_req.redirect, 1);
        chk("redir_target", bus.bpu_req.target, 32'h1c000108);
        chk("redir_next", bus.bpu_req.next, 0);
        chk("redir_valid", bus.ftq_valid, 0);
        tick;
        rv = 0;
        @(negedge clk);
        chk("post_redir_valid", bus.ftq_valid, 0);
        chk("post_redir_next", bus.bpu_req.next, 1);
        chk("post_redir_rsp_mask", bus.bpu_rsp.valid, 4'b1100);
        tick;
        @(negedge clk);
        chk("redir_head_pc", bus.ftq_pc, 32'h1c000108);
        chk("redir_head_mask", bus.ftq_mask, 4'b1100);
        rv = 1;
        rt = 32'h1c000203;
        @(negedge clk);
        chk("misalign_target", bus.bpu_req.target, 32'h1c000200);
        tick;
        rv = 0;
        tick;
        @(negedge clk);
        chk("misalign_pc", bus.ftq_pc, 32'h1c000200);
        chk("misalign_mask", bus.ftq_mask, 4'b1111);
        rv = 1;
        rt = 32'h1c000300;
        tick;
        rt = 32'h1c000344;
        tick;
        rv = 0;
        tick;
        @(negedge clk);
        chk("b2b_pc", bus.ftq_pc, 32'h1c000344);
        chk("b2b_mask", bus.ftq_mask, 4'b1110);
        repeat (2) tick;
        ready = 1;
        rst = 1;
        @(negedge clk);
        chk("midrst_valid", bus.ftq_valid, 0);
        chk("midrst_next", bus.bpu_req.next, 0);
        tick;
        rst = 0;
        @(negedge clk);
        chk("after_rst_valid", bus.ftq_valid, 0);
        chk("after_rst_next", bus.bpu_req.next, 1);
        chk("after_rst_rsp_pc", bus.bpu_rsp.pc, 32'h1c000000);
        tick;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("pass_valid", bus.ftq_valid, 1);
            chk("pass_pc", bus.ftq_pc, 32'h1c000000 + 32'h10 * k);
            tick;
        end
        bubble_en = 1;
        for (int j = 0; j < 3000; j++) begin
            ready = $urandom_range(0, 99) < (((j / 300) % 2 == 1) ? 20 : 90);
            rv = $urandom_range(0, 19) == 0;
            rt = 32'h1c000000 | ($urandom & 32'h0000_0fff);
            rst = $urandom_range(0, 199) == 0;
            tick;
        end
        rst = 0;
        rv = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_target_queue.md
Name: fetch_target_queue

Overview:
- Consumer and driver of the branch-predictor request/response interface.
- Drives BpuReqSt each cycle: next (advance the predictor to the next fetch block) and redirect/target (backend flush).
- Captures each BpuRspSt fetch block (pc plus per-slot valid mask) into a circular FIFO.
- Presents the FIFO head to the instruction-fetch stage over a valid/ready handshake.

Parameters:
- FETCH_WIDTH, 4 (taken from `FETCH_WIDTH), number of instruction slots per fetch block.
- FTQ_DEPTH, 8, number of queue entries; power of two, at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- bpu_req  output  BpuReqSt  {next, redirect, target[31:0]} to the predictor
- bpu_rsp  input  BpuRspSt  {pc[31:0], npc[31:0], valid[FETCH_WIDTH-1:0]} from the predictor
- redirect_valid  input  1  backend flush request
- redirect_target  input  32  flush target PC
- ftq_valid  output  1  head entry available
- ftq_ready  input  1  fetch stage accepts head
- ftq_pc  output  32  head fetch-block PC
- ftq_mask  output  FETCH_WIDTH  head per-slot valid mask

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset state: head_ptr=0, tail_ptr=0, count=0, all entries invalid.
- Outputs while rst=1: bpu_req.next=0, bpu_req.redirect=0, bpu_req.target=0, ftq_valid=0.
- bpu_req.next is combinational: next = !rst && !redirect_valid && (count < FTQ_DEPTH).
  - next must not depend on ftq_ready.
  - A dequeue from a full queue frees space only from the following cycle.
- The predictor gates bpu_rsp.valid with next within the same cycle.
- Enqueue condition: next && |bpu_rsp.valid.
  - On enqueue, write {bpu_rsp.pc, bpu_rsp.valid} at tail_ptr.
  - tail_ptr increments modulo FTQ_DEPTH; the pointer is $clog2(FTQ_DEPTH) bits and wraps naturally.
- An all-zero bpu_rsp.valid is never enqueued.
- ftq_valid = (count != 0) && !redirect_valid.
- ftq_pc and ftq_mask read combinationally from registered storage at head_ptr.
- Dequeue when ftq_valid && ftq_ready: head_ptr increments modulo FTQ_DEPTH.
- count is $clog2(FTQ_DEPTH)+1 bits. On each clock edge it updates as follows:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged when both occur in the same cycle.
- Latency: an enqueued block is visible on ftq_* one cycle after capture. Sustained throughput is 1 block/cycle.
- Redirect cycle (redirect_valid=1):
  - bpu_req.redirect=1 and bpu_req.target={redirect_target[31:2],2'b00}.
  - No enqueue and no dequeue.
  - At the clock edge, head_ptr, tail_ptr and count clear to 0.
  - Entries are not cleared; count=0 makes them unreachable.
- While redirect_valid=0: bpu_req.redirect=0 and bpu_req.target=0.
- First block after a redirect is the block at the target PC. Its mask has slot i set only for i >= target[NPC_OFS-1:2], where NPC_OFS = $clog2(FETCH_WIDTH)+2.
- Back-to-back redirects: each cycle flushes; the last target wins.
- Precedence: rst over redirect_valid over normal operation.
- Reset asserted mid-operation discards all queued blocks. The predictor PC is re-initialised by its own reset.
- Assertions:
  - No enqueue when count==FTQ_DEPTH.
  - No dequeue when count==0.
  - ftq_mask is never zero while ftq_valid=1.

Decomposition:
- Package header FetchTargetQueue.svh:
  - FtqEntrySt {pc[31:0], mask[FETCH_WIDTH-1:0]}.
  - FTQ_DEPTH default.
  - FtqPtrT typedef.
- BpuReqSt and BpuRspSt stay in the existing branch-predictor header.
- One sub-module, ftq_storage:
  - FTQ_DEPTH x FtqEntrySt register array.
  - One write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - No reset on data.
- Pointer and count control stay in the top module.

Test Plan:
- Reset release, ftq_ready=0:
  - next=1 for 8 cycles.
  - Entries captured with pc 0x1c000000, 0x1c000010 … 0x1c000070, each with mask 4'b1111.
  - Ninth cycle: next=0 and count=8.
- ftq_ready=1 held from reset:
  - ftq_valid rises the cycle after the first capture.
  - ftq_pc advances by 0x10 every cycle; count stays at 1.
- Five entries queued, then redirect_valid=1 with target 0x1c000108:
  - Same cycle: bpu_req.redirect=1, target=0x1c000108, next=0, ftq_valid=0.
  - Next cycle: count=0.
  - Cycle after: captured entry pc=0x1c000108, mask=4'b1100.
- Full queue with ftq_ready=1:
  - Head dequeued while next stays 0 that cycle.
  - next=1 the following cycle; count returns to 8 with the new tail at pointer wrap index 0.
- redirect_target=0x1c000203 (misaligned):
  - bpu_req.target=0x1c000200; first mask=4'b1111.
- rst pulsed for 1 cycle with 3 entries queued and ftq_ready=1:
  - ftq_valid=0 and next=0 during the reset cycle; no dequeue counted.
  - After reset: count=0; capture resumes the cycle after rst falls.
